// File: rtl/lcd_frame_sync_detector.sv
// lcd_frame_sync_detector
// Recovers frame timing from the HP54542C LCD line sync: a sync rise that
// follows a long idle gap marks a frame start, and lock is granted only after
// a full frame with the expected line count. Outputs are pixel coordinates,
// data enable, line/frame pulses and the pixel colour, all registered and
// 2 clocks behind the edge that first samples the sync rise.
// Optional build macro LCD_SYNC_ERRCNT_EN adds ow_err_count, a saturating
// count of lock losses, verify mismatches and timeouts.
module lcd_frame_sync_detector #(
  parameter int P_HACTIVE  = 640,
  parameter int P_VACTIVE  = 480,
  parameter int P_HOFFSET  = 0,
  parameter int P_VGAP_MIN = 1000,
  parameter int P_GAPW     = 16
) (
  input  logic       iw_clk,
  input  logic       iw_rst_n,
  input  logic       iw_sync,
  input  logic       iw_r0,
  input  logic       iw_g0,
  input  logic       iw_b0,
  output logic       ow_frame_start,
  output logic       ow_line_start,
  output logic       ow_de,
  output logic [9:0] ow_x,
  output logic [8:0] ow_y,
  output logic       ow_r0,
  output logic       ow_g0,
  output logic       ow_b0,
`ifdef LCD_SYNC_ERRCNT_EN
  output logic [7:0] ow_err_count,
`endif
  output logic       ow_locked
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [P_GAPW-1:0] GAP_MAX = {P_GAPW{1'b1}};
  localparam logic [P_GAPW-1:0] GAP_ONE = {{(P_GAPW-1){1'b0}}, 1'b1};
  localparam logic [P_GAPW-1:0] GAP_MIN = P_GAPW'(P_VGAP_MIN);
  localparam logic [9:0]  V_TGT  = 10'(P_VACTIVE);
  localparam logic [10:0] H_LO   = 11'(P_HOFFSET);
  localparam logic [9:0]  H_LO10 = 10'(P_HOFFSET);
  localparam logic [11:0] H_HI   = 12'(P_HOFFSET + P_HACTIVE);

  // stage 1 / stage 2 input pipeline
  logic              sync_q, sync_d, sync_prev_q, sync_prev_d;
  logic [2:0]        rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  // timing trackers
  logic [P_GAPW-1:0] gap_q, gap_d;
  logic [9:0]        lines_q, lines_d;
  logic [10:0]       h_q, h_d;
  logic [1:0]        state_q, state_d;
  logic              line_pls_q, line_pls_d, frame_pls_q, frame_pls_d;
  // registered outputs
  logic              frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic              de_q, de_d, locked_q, locked_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [2:0]        rgb_out_q, rgb_out_d;

  logic rise_s, sat_s, long_s, match_s;
  logic [9:0] y_full_s;

  assign rise_s   = sync_q & ~sync_prev_q;
  assign sat_s    = (gap_q == GAP_MAX);
  // a rise on a saturated gap always counts as a frame start
  assign long_s   = rise_s & ((gap_q >= GAP_MIN) | sat_s);
  assign match_s  = (lines_q == V_TGT);
  assign y_full_s = lines_q - 10'd1;

  // Input capture and colour pipeline next values
  always_comb begin
    sync_d      = iw_sync;
    sync_prev_d = sync_q;
    rgb1_d      = {iw_r0, iw_g0, iw_b0};
    rgb2_d      = rgb1_q;
  end

  // Gap, line and pixel counters plus the lock state machine
  always_comb begin
    gap_d   = gap_q;
    lines_d = lines_q;
    h_d     = h_q;
    state_d = state_q;
    if (rise_s) begin
      gap_d = GAP_ONE;
      h_d   = 11'd0;
      if (long_s) begin
        lines_d = 10'd1;
      end else if (lines_q != 10'h3FF) begin
        lines_d = lines_q + 10'd1;
      end else begin
        lines_d = lines_q;
      end
      case (state_q)
        S_SEARCH: begin
          if (long_s) state_d = S_VERIFY;
          else        state_d = S_SEARCH;
        end
        S_VERIFY: begin
          if (long_s && match_s) state_d = S_LOCKED;
          else                   state_d = S_VERIFY;
        end
        S_LOCKED: begin
          if (long_s && !match_s) state_d = S_VERIFY;
          else                    state_d = S_LOCKED;
        end
        default: state_d = S_SEARCH;
      endcase
    end else begin
      if (!sat_s) gap_d = gap_q + GAP_ONE;
      else        gap_d = gap_q;
      if (h_q != 11'h7FF) h_d = h_q + 11'd1;
      else                h_d = h_q;
      // no sync rise for the whole gap range: timing lost
      if (sat_s) state_d = S_SEARCH;
      else       state_d = state_q;
    end
    line_pls_d  = rise_s & (state_d == S_LOCKED);
    frame_pls_d = rise_s & (state_d == S_LOCKED) & long_s;
  end

  // Output stage derived from the tracker registers
  always_comb begin
    locked_d      = (state_q == S_LOCKED);
    de_d          = locked_d && (h_q >= H_LO) && ({1'b0, h_q} < H_HI) && (y_full_s < V_TGT);
    frame_start_d = frame_pls_q;
    line_start_d  = line_pls_q;
    if (de_d) begin
      x_d       = h_q[9:0] - H_LO10;
      rgb_out_d = rgb2_q;
    end else begin
      x_d       = 10'd0;
      rgb_out_d = 3'b000;
    end
    if (locked_d) y_d = y_full_s[8:0];
    else          y_d = 9'd0;
  end

  // Pipeline, tracker and output registers
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      sync_q        <= 1'b0;
      sync_prev_q   <= 1'b0;
      rgb1_q        <= 3'b000;
      rgb2_q        <= 3'b000;
      gap_q         <= {P_GAPW{1'b0}};
      lines_q       <= 10'd0;
      h_q           <= 11'd0;
      state_q       <= S_SEARCH;
      line_pls_q    <= 1'b0;
      frame_pls_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      de_q          <= 1'b0;
      locked_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      rgb_out_q     <= 3'b000;
    end else begin
      sync_q        <= sync_d;
      sync_prev_q   <= sync_prev_d;
      rgb1_q        <= rgb1_d;
      rgb2_q        <= rgb2_d;
      gap_q         <= gap_d;
      lines_q       <= lines_d;
      h_q           <= h_d;
      state_q       <= state_d;
      line_pls_q    <= line_pls_d;
      frame_pls_q   <= frame_pls_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      de_q          <= de_d;
      locked_q      <= locked_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_out_q     <= rgb_out_d;
    end
  end

  assign ow_frame_start = frame_start_q;
  assign ow_line_start  = line_start_q;
  assign ow_de          = de_q;
  assign ow_x           = x_q;
  assign ow_y           = y_q;
  assign ow_r0          = rgb_out_q[2];
  assign ow_g0          = rgb_out_q[1];
  assign ow_b0          = rgb_out_q[0];
  assign ow_locked      = locked_q;

`ifdef LCD_SYNC_ERRCNT_EN
  logic       err_inc_q, err_inc_d;
  logic [7:0] errcnt_q, errcnt_d;

  // Error events are flagged with the tracker update and counted one stage later
  always_comb begin
    err_inc_d = ((state_q == S_LOCKED) && (state_d == S_VERIFY)) ||
                ((state_q == S_VERIFY) && long_s && !match_s) ||
                (!rise_s && sat_s && (state_q != S_SEARCH));
    if (err_inc_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
    else                                  errcnt_d = errcnt_q;
  end

  // Error counter registers, cleared only by reset
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      err_inc_q <= 1'b0;
      errcnt_q  <= 8'd0;
    end else begin
      err_inc_q <= err_inc_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign ow_err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_lcd_frame_sync_detector.sv
// Randomized bench for lcd_frame_sync_detector with a reduced-size timing
// configuration; expected outputs come from an event-level frame model.
module tb_lcd_frame_sync_detector;

  localparam int HACT = 12;
  localparam int VACT = 5;
  localparam int HOFF = 2;
  localparam int VGAP = 100;
  localparam int GAPW = 8;
  localparam int GMAX = (1 << GAPW) - 1;

  logic iw_clk = 1'b0, iw_rst_n = 1'b0, iw_sync = 1'b0;
  logic iw_r0 = 1'b0, iw_g0 = 1'b0, iw_b0 = 1'b0;
  logic ow_frame_start, ow_line_start, ow_de, ow_r0, ow_g0, ow_b0, ow_locked;
  logic [9:0] ow_x;
  logic [8:0] ow_y;
`ifdef LCD_SYNC_ERRCNT_EN
  logic [7:0] ow_err_count;
`endif

  lcd_frame_sync_detector #(
    .P_HACTIVE(HACT), .P_VACTIVE(VACT), .P_HOFFSET(HOFF),
    .P_VGAP_MIN(VGAP), .P_GAPW(GAPW)
  ) dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_sync(iw_sync),
    .iw_r0(iw_r0), .iw_g0(iw_g0), .iw_b0(iw_b0),
    .ow_frame_start(ow_frame_start), .ow_line_start(ow_line_start),
    .ow_de(ow_de), .ow_x(ow_x), .ow_y(ow_y),
    .ow_r0(ow_r0), .ow_g0(ow_g0), .ow_b0(ow_b0),
`ifdef LCD_SYNC_ERRCNT_EN
    .ow_err_count(ow_err_count),
`endif
    .ow_locked(ow_locked)
  );

  always #5 iw_clk = ~iw_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef enum int {M_SEARCH, M_VERIFY, M_LOCKED} frame_mode_e;
  frame_mode_e m_mode;
  int m_k, m_last, m_lines, m_h, m_err;
  bit m_prev;
  logic [33:0] exp_q[$];

  function automatic void model_reset();
    m_mode = M_SEARCH; m_k = 0; m_last = 0; m_lines = 0; m_h = 0; m_err = 0; m_prev = 1'b0;
    exp_q = {};
    exp_q.push_back(34'd0);
    exp_q.push_back(34'd0);
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  // Consume one input sample; push the output expected two edges later.
  function automatic void model_step(input bit s, input logic [2:0] rgb);
    int gap, x, y;
    bit rise, lng, lk, de, ls, fs;
    m_k++;
    rise = s && !m_prev;
    m_prev = s;
    gap = m_k - m_last;
    if (gap > GMAX) gap = GMAX;
    ls = 1'b0; fs = 1'b0;
    if (rise) begin
      lng = (gap >= VGAP);
      if (lng) begin
        if (m_mode == M_SEARCH)    m_mode = M_VERIFY;
        else if (m_lines == VACT)  m_mode = M_LOCKED;
        else begin m_mode = M_VERIFY; bump_err(); end
        m_lines = 1;
      end else if (m_lines < 1023) begin
        m_lines++;
      end
      m_last = m_k;
      m_h = 0;
      ls = (m_mode == M_LOCKED);
      fs = ls && lng;
    end else begin
      if (gap >= GMAX) begin
        if (m_mode != M_SEARCH) bump_err();
        m_mode = M_SEARCH;
      end
      if (m_h < 2047) m_h++;
    end
    lk = (m_mode == M_LOCKED);
    y  = lk ? m_lines - 1 : 0;
    de = lk && (m_h >= HOFF) && (m_h < HOFF + HACT) && (m_lines - 1 < VACT);
    x  = de ? m_h - HOFF : 0;
    exp_q.push_back({8'(m_err), lk, fs, ls, de, 10'(x), 9'(y), de ? rgb : 3'b000});
  endfunction

  function automatic logic [33:0] dut_vec();
    logic [7:0] e;
`ifdef LCD_SYNC_ERRCNT_EN
    e = ow_err_count;
`else
    e = 8'd0;
`endif
    return {e, ow_locked, ow_frame_start, ow_line_start, ow_de, ow_x, ow_y, ow_r0, ow_g0, ow_b0};
  endfunction

  // ---------------- observation counters ----------------
  int cyc = 0, fs_cnt = 0, ls_cnt = 0, de_cnt = 0, off_ok = 0, last_ls_cyc = 0;
  bit prev_de = 1'b0;

  task automatic clear_obs();
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; off_ok = 0;
  endtask

  task automatic step(input bit s);
    logic [2:0] c;
    logic [33:0] e, a;
    c = 3'($urandom);
    iw_sync = s;
    {iw_r0, iw_g0, iw_b0} = c;
    model_step(s, c);
    @(posedge iw_clk);
    @(negedge iw_clk);
    e = exp_q.pop_front();
    a = dut_vec();
    check_val("outs", {8'd0, a[25:0]}, {8'd0, e[25:0]});
`ifdef LCD_SYNC_ERRCNT_EN
    check_val("err_count", {26'd0, a[33:26]}, {26'd0, e[33:26]});
`endif
    cyc++;
    if (ow_frame_start) fs_cnt++;
    if (ow_line_start) begin ls_cnt++; last_ls_cyc = cyc; end
    if (ow_de) de_cnt++;
    if (ow_de && !prev_de && (cyc - last_ls_cyc == HOFF) && (ow_x == 10'd0)) off_ok++;
    prev_de = ow_de;
  endtask

  task automatic hold_reset(input int n);
    logic [33:0] a;
    iw_rst_n = 1'b0;
    repeat (n) begin
      iw_sync = 1'($urandom);
      {iw_r0, iw_g0, iw_b0} = 3'($urandom);
      @(posedge iw_clk);
      @(negedge iw_clk);
      a = dut_vec();
      check_val("rst_hold", a, 34'd0);
    end
    iw_sync = 1'b0;
    iw_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_line(input int spacing, input int high);
    for (int i = 0; i < spacing; i++) step(i < high);
  endtask

  task automatic send_frame(input int nlines, input int smin, input int smax, input int last);
    int sp, hi;
    for (int l = 0; l < nlines; l++) begin
      sp = (l == nlines - 1) ? last : int'($urandom_range(smax, smin));
      hi = int'($urandom_range((sp > 7) ? 6 : sp - 1, 1));
      send_line(sp, hi);
    end
  endtask

  initial begin
    model_reset();
    hold_reset(10);
    repeat (150) step(1'b0);

    // three ideal frames, observe the third
    for (int f = 0; f < 3; f++) begin
      if (f == 2) clear_obs();
      for (int l = 0; l < VACT; l++) send_line((l == VACT - 1) ? 150 : 30, 6);
    end
    check_val("f3_frame_starts", 34'(fs_cnt), 34'd1);
    check_val("f3_line_starts", 34'(ls_cnt), 34'(VACT));
    check_val("f3_de_cycles", 34'(de_cnt), 34'(VACT * HACT));
    check_val("f3_de_offset", 34'(off_ok), 34'(VACT));
    check_val("ideal_locked", {33'd0, ow_locked}, 34'd1);

    // short frame drops lock, next frames relock
    send_frame(VACT - 1, 20, 40, 150);
    send_frame(VACT, 20, 40, 150);
    check_val("short_drop", {33'd0, ow_locked}, 34'd0);
    send_frame(VACT, 20, 40, 150);
    check_val("short_relock", {33'd0, ow_locked}, 34'd1);
`ifdef LCD_SYNC_ERRCNT_EN
    check_val("err_after_short", {26'd0, ow_err_count}, 34'd1);
`endif

    // gap exactly at threshold is a frame start
    send_frame(VACT, 20, 40, VGAP);
    send_frame(VACT, 20, 40, 150);
    check_val("gap_eq_min", {33'd0, ow_locked}, 34'd1);
    // gap one below threshold counts as a line
    send_frame(VACT - 1, 20, 40, VGAP - 1);
    send_line(150, 6);
    send_frame(VACT, 20, 40, 150);
    check_val("gap_below_min", {33'd0, ow_locked}, 34'd1);

    // timeout while locked
    repeat (GMAX + 40) step(1'b0);
    check_val("to_locked", {33'd0, ow_locked}, 34'd0);
    check_val("to_de", {33'd0, ow_de}, 34'd0);
    check_val("to_y", {25'd0, ow_y}, 34'd0);
    send_frame(VACT, 20, 40, 150);
    send_frame(VACT, 20, 40, 150);
    check_val("to_relock", {33'd0, ow_locked}, 34'd1);

    // asynchronous reset mid-line while locked
    repeat (3) step(1'b1);
    repeat (6) step(1'b0);
    check_val("pre_async_locked", {33'd0, ow_locked}, 34'd1);
    #2;
    iw_rst_n = 1'b0;
    #1;
    check_val("async_rst", dut_vec(), 34'd0);
    hold_reset(4);
    repeat (150) step(1'b0);

    // randomized frames: line count, line spacing and frame gap all vary
    for (int f = 0; f < 30; f++) begin
      int nl, pick;
      pick = int'($urandom_range(4, 0));
      nl = (pick == 0) ? VACT - 1 : (pick == 4) ? VACT + 1 : VACT;
      send_frame(nl, 6, 40, int'($urandom_range(270, 90)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
